// File: rtl/ben_cpu_pkg.sv
// Shared definitions for the CPU run-control slice.
package ben_cpu_pkg;

    // Run-control FSM encoding, also exported on o_state.
    typedef enum logic [1:0] {
        ST_STOP   = 2'd0,
        ST_RUN    = 2'd1,
        ST_STEP   = 2'd2,
        ST_HALTED = 2'd3
    } run_state_e;

    // 10 ms at 50 MHz.
    localparam int unsigned DB_CYCLES_DEFAULT = 500000;
    localparam int unsigned DB_W_DEFAULT      = 20;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus stability counter for a bouncing push-button.
module btn_debounce #(
    parameter int unsigned DB_CYCLES = 500000,
    parameter int unsigned DB_W      = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic level,
    output logic rise
);

    localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DB_CYCLES - 1);

    logic            btn_s1;
    logic            btn_sync;
    logic [DB_W-1:0] cnt;

    // Bring the raw button into the clock domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_s1   <= 1'b0;
            btn_sync <= 1'b0;
        end else begin
            btn_s1   <= btn;
            btn_sync <= btn_s1;
        end
    end

    // Accept a new level only after it has persisted DB_CYCLES cycles; any bounce back restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            rise <= 1'b0;
            if (btn_sync == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                level <= btn_sync;
                rise  <= btn_sync;
            end else begin
                cnt <= cnt + DB_W'(1);
            end
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/stop/single-step sequencer issuing one-cycle clock-enable pulses to the CPU.
module cpu_run_ctrl
    import ben_cpu_pkg::*;
#(
    parameter int unsigned DIV_W     = 32,
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT,
    parameter int unsigned DB_W      = DB_W_DEFAULT,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [DIV_W-1:0] i_divider,
    input  logic             i_run_sw,
    input  logic             i_step_btn,
    input  logic             i_cpu_hlt,
    input  logic             i_hlt_clr,
    output logic             o_cpu_en,
    output logic [1:0]       o_state,
    output logic [CNT_W-1:0] o_en_count
);

    logic             run_s1;
    logic             run_sync;
    logic             step_level;
    logic             step_rise;
    logic             step_req;
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] latched_div;
    logic             tick_c;
    logic             pulse_c;
    run_state_e       state;
    run_state_e       state_nxt;

    // Run switch synchroniser.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            run_s1   <= 1'b0;
            run_sync <= 1'b0;
        end else begin
            run_s1   <= i_run_sw;
            run_sync <= run_s1;
        end
    end

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES),
        .DB_W      (DB_W)
    ) u_step_db (
        .clk   (i_clk),
        .rst_n (i_rst),
        .btn   (i_step_btn),
        .level (step_level),
        .rise  (step_rise)
    );

    // The rise pulse only ever accompanies the new high level.
    assign step_req = step_rise & step_level;

    assign tick_c = (div_cnt == latched_div - DIV_W'(1));

    // Free-running divider; the period is reloaded only at a tick so a switch change never yields a runt period.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            div_cnt     <= '0;
            latched_div <= DIV_W'(1);
        end else if (tick_c) begin
            div_cnt     <= '0;
            latched_div <= (i_divider == '0) ? DIV_W'(1) : i_divider;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state <= ST_STOP;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic; a halt outranks everything except the explicit clear.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_STOP: begin
                if (run_sync) begin
                    state_nxt = ST_RUN;
                end else if (step_req) begin
                    state_nxt = ST_STEP;
                end
            end
            ST_RUN: begin
                if (i_cpu_hlt) begin
                    state_nxt = ST_HALTED;
                end else if (!run_sync) begin
                    state_nxt = ST_STOP;
                end
            end
            ST_STEP: begin
                if (i_cpu_hlt) begin
                    state_nxt = ST_HALTED;
                end else if (tick_c) begin
                    state_nxt = ST_STOP;
                end
            end
            ST_HALTED: begin
                if (i_hlt_clr) begin
                    state_nxt = ST_STOP;
                end
            end
            default: state_nxt = ST_STOP;
        endcase
    end

    // FSM output decode: pulse decision for this tick.
    always_comb begin
        pulse_c = 1'b0;
        unique case (state)
            ST_RUN:    pulse_c = tick_c & ~i_cpu_hlt;
            ST_STEP:   pulse_c = tick_c & ~i_cpu_hlt;
            ST_STOP:   pulse_c = 1'b0;
            ST_HALTED: pulse_c = 1'b0;
            default:   pulse_c = 1'b0;
        endcase
    end

    // Registered enable pulse and issued-pulse counter move together.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_cpu_en   <= 1'b0;
            o_en_count <= '0;
        end else begin
            o_cpu_en <= pulse_c;
            if (pulse_c) begin
                o_en_count <= o_en_count + CNT_W'(1);
            end
        end
    end

    assign o_state = state;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl: cycle model plus directed scenarios and random traffic.
module tb_cpu_run_ctrl;

    localparam int unsigned DB = 8;

    logic        clk = 1'b0;
    logic        i_rst = 1'b0;
    logic [31:0] i_divider = '0;
    logic        i_run_sw = 1'b0;
    logic        i_step_btn = 1'b0;
    logic        i_cpu_hlt = 1'b0;
    logic        i_hlt_clr = 1'b0;
    logic        o_cpu_en;
    logic [1:0]  o_state;
    logic [15:0] o_en_count;

    int n_tests = 0;
    int n_fail  = 0;

    cpu_run_ctrl #(
        .DIV_W     (32),
        .DB_CYCLES (DB),
        .DB_W      (4),
        .CNT_W     (16)
    ) dut (
        .i_clk      (clk),
        .i_rst      (i_rst),
        .i_divider  (i_divider),
        .i_run_sw   (i_run_sw),
        .i_step_btn (i_step_btn),
        .i_cpu_hlt  (i_cpu_hlt),
        .i_hlt_clr  (i_hlt_clr),
        .o_cpu_en   (o_cpu_en),
        .o_state    (o_state),
        .o_en_count (o_en_count)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // States: 0 STOP, 1 RUN, 2 STEP, 3 HALTED.
    bit          m_run_q[2];
    bit          m_btn_q[2];
    bit          m_level;
    int          m_streak;
    bit          m_step_req;
    int unsigned m_phase;
    int unsigned m_period;
    int          m_state;
    bit          m_en;
    int          m_count;

    task automatic model_reset();
        m_run_q[0] = 0; m_run_q[1] = 0;
        m_btn_q[0] = 0; m_btn_q[1] = 0;
        m_level = 0; m_streak = 0; m_step_req = 0;
        m_phase = 0; m_period = 1;
        m_state = 0; m_en = 0; m_count = 0;
    endtask

    task automatic model_step();
        bit run_s;
        bit btn_s;
        bit tick;
        bit pulse;
        int nxt;
        run_s = m_run_q[1];
        btn_s = m_btn_q[1];
        tick  = (m_phase == m_period - 1);
        pulse = 0;
        nxt   = m_state;
        case (m_state)
            0: if (run_s) nxt = 1; else if (m_step_req) nxt = 2;
            1: if (i_cpu_hlt) nxt = 3; else begin pulse = tick; if (!run_s) nxt = 0; end
            2: if (i_cpu_hlt) nxt = 3; else if (tick) begin pulse = 1; nxt = 0; end
            default: if (i_hlt_clr) nxt = 0;
        endcase
        m_state = nxt;
        m_en    = pulse;
        if (pulse) m_count = (m_count + 1) % 65536;
        // Level follows the synced button once it has differed for DB consecutive cycles.
        m_step_req = 0;
        if (btn_s != m_level) begin
            m_streak++;
            if (m_streak == DB) begin
                m_level    = btn_s;
                m_streak   = 0;
                m_step_req = m_level;
            end
        end else begin
            m_streak = 0;
        end
        if (tick) begin
            m_phase  = 0;
            m_period = (i_divider == 0) ? 1 : i_divider;
        end else begin
            m_phase++;
        end
        m_run_q[1] = m_run_q[0]; m_run_q[0] = i_run_sw;
        m_btn_q[1] = m_btn_q[0]; m_btn_q[0] = i_step_btn;
    endtask

    initial model_reset();

    always @(posedge clk or negedge i_rst) begin
        if (!i_rst) model_reset();
        else        model_step();
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (i_rst) begin
            n_tests++;
            if (o_cpu_en !== m_en || o_state !== 2'(m_state) || o_en_count !== 16'(m_count)) begin
                n_fail++;
                $display("FAIL model_cmp t=%0t: got en=%0d st=%0d cnt=%0d, expected en=%0d st=%0d cnt=%0d",
                         $time, o_cpu_en, o_state, o_en_count, m_en, m_state, m_count);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Wait for the next enable pulse; returns cycles elapsed.
    task automatic wait_pulse(input string name, input int max_cyc, output int gap);
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (!o_cpu_en && gap < max_cyc);
        check({name, "_seen"}, longint'(o_cpu_en), 1);
    endtask

    task automatic wait_state(input string name, input int st, input int max_cyc);
        int n;
        n = 0;
        while (o_state != 2'(st) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check(name, longint'(o_state), st);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int gap;
        int base;
        int pulses;
        int lim;

        // Reset state.
        cycles(3);
        check("rst_en", longint'(o_cpu_en), 0);
        check("rst_state", longint'(o_state), 0);
        check("rst_count", longint'(o_en_count), 0);
        i_rst = 1'b1;
        cycles(2);

        // 1: free-run at divider 4.
        i_divider = 4;
        i_run_sw  = 1'b1;
        wait_pulse("t1_first", 20, gap);
        check("t1_first_latency_le9", longint'(gap <= 9), 1);
        wait_pulse("t1_p2", 20, gap);
        check("t1_gap2", gap, 4);
        wait_pulse("t1_p3", 20, gap);
        check("t1_gap3", gap, 4);
        check("t1_count3", longint'(o_en_count), 3);

        // 2: divider change mid-period takes effect after the current period.
        cycles(1);
        i_divider = 2;
        wait_pulse("t2_p1", 20, gap);
        check("t2_old_period", gap + 1, 4);
        wait_pulse("t2_p2", 20, gap);
        check("t2_new_period", gap, 2);
        i_divider = 0;
        wait_pulse("t2_flush", 20, gap);
        for (int k = 0; k < 3; k++) begin
            wait_pulse("t2_div0", 20, gap);
            check("t2_div0_gap", gap, 1);
        end

        // 3: bouncing step button produces exactly one pulse.
        i_run_sw = 1'b0;
        wait_state("t3_stop", 0, 20);
        cycles(2);
        base = int'(o_en_count);
        for (int k = 0; k < 5; k++) begin
            i_step_btn = 1'b1; cycles(3);
            i_step_btn = 1'b0; cycles(3);
        end
        check("t3_no_early_pulse", longint'(o_en_count), base);
        i_step_btn = 1'b1; cycles(DB + 2);
        i_step_btn = 1'b0; cycles(25);
        check("t3_one_pulse", longint'(o_en_count) - base, 1);
        check("t3_back_stop", longint'(o_state), 0);

        // 4: halt on a tick cycle, then clear.
        i_divider = 3;
        i_run_sw  = 1'b1;
        wait_state("t4_run", 1, 20);
        wait_pulse("t4_a", 20, gap);
        wait_pulse("t4_b", 20, gap);
        check("t4_period", gap, 3);
        base = int'(o_en_count);
        cycles(2);
        i_cpu_hlt = 1'b1;
        cycles(1);
        check("t4_no_pulse", longint'(o_cpu_en), 0);
        check("t4_halted", longint'(o_state), 3);
        cycles(1);
        check("t4_sticky", longint'(o_state), 3);
        check("t4_count_held", longint'(o_en_count), base);
        i_hlt_clr = 1'b1;
        cycles(1);
        check("t4_clr_stop", longint'(o_state), 0);
        i_hlt_clr = 1'b0;
        i_cpu_hlt = 1'b0;
        cycles(1);
        check("t4_rerun", longint'(o_state), 1);

        // 5: asynchronous reset in STEP before its tick.
        i_run_sw  = 1'b0;
        i_divider = 50;
        cycles(60);
        check("t5_stop", longint'(o_state), 0);
        i_step_btn = 1'b1;
        wait_state("t5_step", 2, 30);
        #2;
        i_rst = 1'b0;
        #1;
        check("t5_async_en", longint'(o_cpu_en), 0);
        check("t5_async_state", longint'(o_state), 0);
        check("t5_async_count", longint'(o_en_count), 0);
        i_step_btn = 1'b0;
        cycles(2);
        i_rst = 1'b1;
        cycles(60);
        check("t5_no_pulse_count", longint'(o_en_count), 0);
        check("t5_state_after", longint'(o_state), 0);

        // Random traffic, checked cycle by cycle against the model.
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if ($urandom_range(0, 99) < 3) i_run_sw = ~i_run_sw;
            if ($urandom_range(0, 99) < 2) i_divider = $urandom_range(0, 5);
            if ($urandom_range(0, 99) < 5) i_step_btn = ~i_step_btn;
            i_cpu_hlt = ($urandom_range(0, 99) < 2);
            i_hlt_clr = ($urandom_range(0, 99) < 4);
        end
        i_cpu_hlt  = 1'b0;
        i_hlt_clr  = 1'b1;
        i_run_sw   = 1'b0;
        i_step_btn = 1'b0;
        cycles(1);
        i_hlt_clr = 1'b0;
        cycles(30);

        // 6: counter wrap after 65537 pulses from reset at divider 1.
        i_rst = 1'b0;
        cycles(2);
        i_divider = 1;
        i_run_sw  = 1'b1;
        i_rst     = 1'b1;
        pulses = 0;
        lim    = 0;
        while (pulses < 65537 && lim < 70000) begin
            @(negedge clk);
            lim++;
            if (o_cpu_en) pulses++;
        end
        check("t6_pulses", pulses, 65537);
        check("t6_wrap", longint'(o_en_count), 1);
        check("t6_model_wrap", m_count, 1);
        i_run_sw = 1'b0;
        cycles(10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
